// File: rtl/e203_sim_irq_injector_pkg.sv
// Shared types and helpers for the E203 simulation interrupt injector.
// Holds the channel state encoding, the LFSR taps and the gap selection rule.
package e203_sim_irq_pkg;

    typedef enum logic [1:0] {
        CH_IDLE   = 2'd0,
        CH_WAIT   = 2'd1,
        CH_ASSERT = 2'd2,
        CH_DONE   = 2'd3
    } ch_state_e;

    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] SEED_MIX  = 32'h9E37_79B9;

    // One step of the 32-bit Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        lfsr_step = v[0] ? ((v >> 1) ^ LFSR_TAPS) : (v >> 1);
    endfunction

    // An all-zero LFSR state would lock up, so a zero seed is replaced by 1.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        seed_fix = (s == 32'h0) ? 32'h1 : s;
    endfunction

    // Fixed gap wins when nonzero; otherwise the random field plus one (range 1..2^GAP_W).
    function automatic logic [16:0] gap_sel(input logic [15:0] fixed_gap, input logic [15:0] rnd);
        gap_sel = (fixed_gap != 16'h0) ? {1'b0, fixed_gap} : ({1'b0, rnd} + 17'd1);
    endfunction

endpackage

// File: rtl/e203_sim_irq_injector_if.sv
// Instruction commit stream observed by the interrupt injector.
interface e203_sim_irq_injector_if #(
    parameter int PC_W = 32
);
    logic            cmt_valid;
    logic [PC_W-1:0] cmt_pc;

    modport master (output cmt_valid, output cmt_pc);
    modport slave  (input  cmt_valid, input  cmt_pc);
endinterface

// File: rtl/e203_sim_irq_injector_chnl.sv
// One interrupt channel: gap wait, assert until ack or timeout, then re-arm or finish.
module e203_sim_irq_chnl
    import e203_sim_irq_pkg::*;
#(
    parameter int          GAP_W   = 10,
    parameter int          CNT_W   = 16,
    parameter int          ACK_TMO = 4096,
    parameter logic [31:0] SEED    = 32'h1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ch_en,
    input  logic             armed,
    input  logic             stop,
    input  logic             ack_hit,
    input  logic [GAP_W-1:0] fixed_gap,
    output logic             irq,
    output logic [CNT_W-1:0] inj_cnt,
    output logic             tmo_err
);

    localparam int                GC_W     = GAP_W + 1;
    localparam int                TMO_W    = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
    localparam bit                TMO_ON   = (ACK_TMO != 0);
    localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'((ACK_TMO > 0) ? (ACK_TMO - 1) : 0);

    ch_state_e        state_r, state_s;
    logic [GC_W-1:0]  gap_cnt_r, gap_cnt_s, gap_new_s;
    logic [TMO_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic [31:0]      lfsr_r, lfsr_s;
    logic [CNT_W-1:0] inj_cnt_r, inj_cnt_s;
    logic             tmo_err_r, tmo_err_s;
    logic             irq_r;
    logic             load_s;
    logic             tmo_hit_s;

    // Next-state logic; every gap load also advances the LFSR exactly once.
    always_comb begin
        state_s   = state_r;
        gap_cnt_s = gap_cnt_r;
        tmo_cnt_s = tmo_cnt_r;
        lfsr_s    = lfsr_r;
        inj_cnt_s = inj_cnt_r;
        tmo_err_s = tmo_err_r;
        load_s    = 1'b0;
        gap_new_s = GC_W'(gap_sel(16'(fixed_gap), 16'(lfsr_r[GAP_W-1:0])));
        tmo_hit_s = TMO_ON && (tmo_cnt_r == TMO_LAST);
        if (!en) begin
            state_s = CH_IDLE;
        end else begin
            case (state_r)
                CH_IDLE: begin
                    if (ch_en && armed && !stop) begin
                        state_s = CH_WAIT;
                        load_s  = 1'b1;
                    end else begin
                        state_s = CH_IDLE;
                    end
                end
                CH_WAIT: begin
                    if (stop) begin
                        state_s = CH_DONE;
                    end else if (!ch_en) begin
                        state_s = CH_IDLE;
                    end else if (gap_cnt_r == GC_W'(1)) begin
                        state_s   = CH_ASSERT;
                        tmo_cnt_s = '0;
                    end else begin
                        gap_cnt_s = gap_cnt_r - GC_W'(1);
                    end
                end
                CH_ASSERT: begin
                    tmo_cnt_s = tmo_cnt_r + TMO_W'(1);
                    // An ack landing on the timeout cycle still counts as a clean ack.
                    if (ack_hit || tmo_hit_s) begin
                        if (ack_hit) begin
                            inj_cnt_s = (inj_cnt_r == {CNT_W{1'b1}}) ? inj_cnt_r : (inj_cnt_r + CNT_W'(1));
                        end else begin
                            tmo_err_s = 1'b1;
                        end
                        if (stop) begin
                            state_s = CH_DONE;
                        end else begin
                            state_s = CH_WAIT;
                            load_s  = 1'b1;
                        end
                    end else begin
                        state_s = CH_ASSERT;
                    end
                end
                CH_DONE: begin
                    state_s = CH_DONE;
                end
                default: begin
                    state_s = CH_IDLE;
                end
            endcase
        end
        if (load_s) begin
            gap_cnt_s = gap_new_s;
            lfsr_s    = lfsr_step(lfsr_r);
        end else begin
            lfsr_s    = lfsr_r;
        end
    end

    // Channel state and registered interrupt output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= CH_IDLE;
            gap_cnt_r <= '0;
            tmo_cnt_r <= '0;
            lfsr_r    <= SEED;
            inj_cnt_r <= '0;
            tmo_err_r <= 1'b0;
            irq_r     <= 1'b0;
        end else begin
            state_r   <= state_s;
            gap_cnt_r <= gap_cnt_s;
            tmo_cnt_r <= tmo_cnt_s;
            lfsr_r    <= lfsr_s;
            inj_cnt_r <= inj_cnt_s;
            tmo_err_r <= tmo_err_s;
            irq_r     <= (state_s == CH_ASSERT);
        end
    end

    assign irq     = irq_r;
    assign inj_cnt = inj_cnt_r;
    assign tmo_err = tmo_err_r;

endmodule

// File: rtl/e203_sim_irq_injector.sv
// Interrupt stimulus generator: arms on a setup PC, drives CH_NUM channels,
// and stops injecting once the tohost commit count passes a threshold.
module e203_sim_irq_injector
    import e203_sim_irq_pkg::*;
#(
    parameter int          CH_NUM    = 3,
    parameter int          PC_W      = 32,
    parameter int          CNT_W     = 16,
    parameter int          GAP_W     = 10,
    parameter int          ACK_TMO   = 4096,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2D5B
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [CH_NUM-1:0]       ch_en,
    e203_sim_irq_injector_if.slave  cmt,
    input  logic [PC_W-1:0]         arm_pc,
    input  logic [PC_W-1:0]         stop_pc,
    input  logic [CNT_W-1:0]        stop_thresh,
    input  logic [CH_NUM*PC_W-1:0]  ack_pc,
    input  logic [GAP_W-1:0]        fixed_gap,
    output logic [CH_NUM-1:0]       irq_o,
    output logic                    armed_o,
    output logic                    stop_o,
    output logic                    done_o,
    output logic [CNT_W-1:0]        stop_cnt_o,
    output logic [CH_NUM*CNT_W-1:0] inj_cnt_o,
    output logic [CH_NUM-1:0]       tmo_err_o
);

    logic             arm_hit_s;
    logic             stop_hit_s;
    logic             armed_r;
    logic             stop_r;
    logic [CNT_W-1:0] stop_cnt_r;
    logic [CH_NUM-1:0] irq_s;

    assign arm_hit_s  = cmt.cmt_valid && (cmt.cmt_pc == arm_pc);
    assign stop_hit_s = cmt.cmt_valid && (cmt.cmt_pc == stop_pc);

    // Sticky arm flag, saturating tohost count, and stop compare on the registered count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r    <= 1'b0;
            stop_cnt_r <= '0;
            stop_r     <= 1'b0;
        end else begin
            armed_r    <= armed_r | arm_hit_s;
            if (stop_hit_s && (stop_cnt_r != {CNT_W{1'b1}})) begin
                stop_cnt_r <= stop_cnt_r + CNT_W'(1);
            end else begin
                stop_cnt_r <= stop_cnt_r;
            end
            stop_r     <= (stop_cnt_r > stop_thresh);
        end
    end

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic ack_hit_s;
        assign ack_hit_s = cmt.cmt_valid && (cmt.cmt_pc == ack_pc[i*PC_W +: PC_W]);

        e203_sim_irq_chnl #(
            .GAP_W   (GAP_W),
            .CNT_W   (CNT_W),
            .ACK_TMO (ACK_TMO),
            .SEED    (seed_fix(LFSR_SEED ^ (32'(i) * SEED_MIX)))
        ) u_chnl (
            .clk       (clk),
            .rst_n     (rst_n),
            .en        (en),
            .ch_en     (ch_en[i]),
            .armed     (armed_r),
            .stop      (stop_r),
            .ack_hit   (ack_hit_s),
            .fixed_gap (fixed_gap),
            .irq       (irq_s[i]),
            .inj_cnt   (inj_cnt_o[i*CNT_W +: CNT_W]),
            .tmo_err   (tmo_err_o[i])
        );
    end

    assign irq_o      = irq_s;
    assign armed_o    = armed_r;
    assign stop_o     = stop_r;
    assign stop_cnt_o = stop_cnt_r;
    assign done_o     = stop_r & (irq_s == '0);

endmodule
